ibex_mem_port_arbiter: RTL

- Shares one OBI-style memory port between the instruction-fetch requester and the load/store requester.
- Data accesses have priority. A starvation counter guarantees fetch forward progress.
- A per-transaction owner FIFO routes in-order responses back to the requester that issued them.
- Sits between the core's IF/LSU stages and the single external memory interface. busy_o feeds the controller's sleep/fence logic.

---
 rtl/ibex_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ibex_mem_port_arbiter.sv
// ibex_mem_port_arbiter
// Shares the single external memory port between instruction fetch and the
// load/store unit. Data accesses win by default, a starvation counter lets a
// waiting fetch through, and an owner FIFO steers the in-order responses back
// to whichever requester issued each transaction.
module ibex_mem_port_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,

  output logic        busy_o,
  output logic        resp_unexpected_o
);

  // A depth of one still needs a one-bit pointer so the array index is legal.
  localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
  localparam int unsigned StarveW = $clog2(StarveLimit + 1);

  localparam logic [PtrW-1:0]    PtrLast   = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0]    CntFull   = CntW'(MaxOutstanding);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLimit);

  typedef enum logic {
    OwnerInstr = 1'b0,
    OwnerData  = 1'b1
  } owner_e;

  // The lock remembers who was on the bus when a request went unanswered, so
  // the address phase cannot change under a stalled request.
  typedef enum logic [1:0] {
    LockIdle  = 2'b00,
    LockInstr = 2'b01,
    LockData  = 2'b10
  } lock_state_e;

  lock_state_e        lock_q, lock_d;

  logic               sel_valid;
  owner_e             sel_owner;
  logic               sel_req;
  logic               starve_win;
  logic               bus_fire;

  logic               owner_q [MaxOutstanding];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    fifo_cnt_q;
  logic               fifo_full, fifo_empty;
  logic               fifo_push, fifo_pop;
  owner_e             head_owner;
  logic               resp_valid;

  logic [StarveW-1:0] starve_cnt_q;
  logic               unexpected_q;

  // Wrap-around increment for the owner FIFO pointers.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrLast) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  assign fifo_full  = (fifo_cnt_q == CntFull);
  assign fifo_empty = (fifo_cnt_q == '0);

  // A fetch that has lost StarveLimit times in a row overrides data priority.
  assign starve_win = instr_req_i && (starve_cnt_q == StarveMax);

  // Pick the requester that owns the address phase this cycle.
  always_comb begin
    sel_valid = 1'b0;
    sel_owner = OwnerInstr;
    unique case (lock_q)
      LockInstr: begin
        sel_valid = 1'b1;
        sel_owner = OwnerInstr;
      end
      LockData: begin
        sel_valid = 1'b1;
        sel_owner = OwnerData;
      end
      default: begin
        if (data_req_i && !starve_win) begin
          sel_valid = 1'b1;
          sel_owner = OwnerData;
        end else if (instr_req_i) begin
          sel_valid = 1'b1;
          sel_owner = OwnerInstr;
        end
      end
    endcase
  end

  assign sel_req   = sel_valid && ((sel_owner == OwnerData) ? data_req_i : instr_req_i);
  assign bus_req_o = sel_req && !fifo_full;
  assign bus_fire  = bus_req_o && bus_gnt_i;

  // Grants only reach the requester whose address is currently on the bus.
  assign instr_gnt_o = bus_fire && (sel_owner == OwnerInstr);
  assign data_gnt_o  = bus_fire && (sel_owner == OwnerData);

  // Drive the address phase from the selected requester; fetches are always
  // full-word reads.
  always_comb begin
    bus_addr_o  = instr_addr_i;
    bus_we_o    = 1'b0;
    bus_be_o    = 4'b1111;
    bus_wdata_o = 32'h0;
    if (sel_owner == OwnerData) begin
      bus_addr_o  = data_addr_i;
      bus_we_o    = data_we_i;
      bus_be_o    = data_be_i;
      bus_wdata_o = data_wdata_i;
    end
  end

  // Lock on an ungranted request and release it on the grant; if a requester
  // withdraws without a grant the lock simply stays where it is.
  always_comb begin
    lock_d = lock_q;
    if (bus_fire) begin
      lock_d = LockIdle;
    end else if (bus_req_o) begin
      lock_d = (sel_owner == OwnerData) ? LockData : LockInstr;
    end
  end

  // Lock state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= LockIdle;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign fifo_push  = bus_fire;
  assign fifo_pop   = bus_rvalid_i && !fifo_empty;
  assign head_owner = owner_e'(owner_q[rd_ptr_q]);

  // Owner FIFO: one entry per granted transaction, retired by each response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        owner_q[i] <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) begin
        owner_q[wr_ptr_q] <= sel_owner;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (fifo_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Responses go straight through to the head owner; a response with nothing
  // outstanding is swallowed.
  assign resp_valid     = fifo_pop;
  assign instr_rvalid_o = resp_valid && (head_owner == OwnerInstr);
  assign data_rvalid_o  = resp_valid && (head_owner == OwnerData);
  assign instr_err_o    = instr_rvalid_o && bus_err_i;
  assign data_err_o     = data_rvalid_o && bus_err_i;
  assign instr_rdata_o  = bus_rdata_i;
  assign data_rdata_o   = bus_rdata_i;

  // Count consecutive cycles a waiting fetch loses to data, cleared when the
  // fetch is finally granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else if (instr_gnt_o) begin
      starve_cnt_q <= '0;
    end else if (instr_req_i && sel_valid && (sel_owner == OwnerData) &&
                 (starve_cnt_q != StarveMax)) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  // Sticky flag for a response that arrived with no transaction outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unexpected_q <= 1'b0;
    end else if (bus_rvalid_i && fifo_empty) begin
      unexpected_q <= 1'b1;
    end
  end

  assign resp_unexpected_o = unexpected_q;
  assign busy_o            = !fifo_empty;

endmodule
